// File: rtl/fc_layer_seq.sv
// -----------------------------------------------------------------------------
// fc_layer_seq
//   Time-multiplexed fully-connected layer. A single signed fixed-point MAC
//   evaluates data_o[j] = act(bias_i[j] + sum_i weights_i[j][i] * data_i[i]).
//   It performs one product per clock, so a full vector takes
//   INPUT_SIZE * OUTPUT_SIZE cycles.
//
//   The layer accepts a vector with a ready/valid handshake. It presents the
//   result with a valid/yumi handshake.
//
//   Each neuron is finalised as follows:
//     1. Arithmetic shift right by FRAC_BITS, which floors the value.
//     2. Saturate to the WORD_SIZE signed range.
//     3. Optionally apply ReLU.
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   reset_i    synchronous active-high reset
//   valid_i    data_i / weights_i / bias_i are valid
//   ready_o    layer is idle and will accept a vector
//   data_i     input vector, INPUT_SIZE signed words
//   weights_i  weight matrix, row j belongs to neuron j
//   bias_i     one bias per neuron
//   valid_o    data_o holds a finished result
//   yumi_i     consumer takes the result (only meaningful while valid_o)
//   data_o     layer output, OUTPUT_SIZE signed words
// -----------------------------------------------------------------------------
module fc_layer_seq #(
   parameter int WORD_SIZE   = 16,
   parameter int INPUT_SIZE  = 4,
   parameter int OUTPUT_SIZE = 3,
   parameter int FRAC_BITS   = 8,
   parameter int RELU        = 1
) (
   input  logic                                              clk_i,
   input  logic                                              reset_i,
   input  logic                                              valid_i,
   output logic                                              ready_o,
   input  logic [INPUT_SIZE-1:0][WORD_SIZE-1:0]              data_i,
   input  logic [OUTPUT_SIZE-1:0][INPUT_SIZE-1:0][WORD_SIZE-1:0] weights_i,
   input  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0]             bias_i,
   output logic                                              valid_o,
   input  logic                                              yumi_i,
   output logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0]             data_o
);

   // Wide enough to hold bias << FRAC_BITS plus INPUT_SIZE full products.
   localparam int ACC_W = 2*WORD_SIZE + $clog2(INPUT_SIZE+1) + 1;
   localparam int I_W   = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
   localparam int J_W   = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

   localparam logic [I_W-1:0] LAST_I = I_W'(INPUT_SIZE-1);
   localparam logic [J_W-1:0] LAST_J = J_W'(OUTPUT_SIZE-1);

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [INPUT_SIZE-1:0][WORD_SIZE-1:0]                  data_r;
   logic [OUTPUT_SIZE-1:0][INPUT_SIZE-1:0][WORD_SIZE-1:0] weights_r;
   logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0]                 bias_r;

   logic signed [ACC_W-1:0]       acc;
   logic [I_W-1:0]                i_cnt;
   logic [J_W-1:0]                j_cnt;
   logic [J_W-1:0]                j_nxt;

   logic signed [2*WORD_SIZE-1:0] mul_a, mul_b, prod;
   logic signed [ACC_W-1:0]       acc_sum, acc_shift, acc_reload;
   logic [WORD_SIZE-1:0]          fin_word;
   logic                          last_mac;

   // Sign-extend a bias word and align it with the product binary point.
   function automatic logic signed [ACC_W-1:0] bias_load(input logic [WORD_SIZE-1:0] b);
      logic signed [ACC_W-1:0] ext;
      ext = {{(ACC_W-WORD_SIZE){b[WORD_SIZE-1]}}, b};
      return ext <<< FRAC_BITS;
   endfunction

   // ---------------------------------------------------------------------------
   // MAC datapath
   // ---------------------------------------------------------------------------

   // Operands are sign-extended to the product width. The low 2*WORD_SIZE
   // bits of the product are then the exact signed result.
   assign mul_a = {{WORD_SIZE{data_r[i_cnt][WORD_SIZE-1]}}, data_r[i_cnt]};
   assign mul_b = {{WORD_SIZE{weights_r[j_cnt][i_cnt][WORD_SIZE-1]}},
                   weights_r[j_cnt][i_cnt]};
   assign prod  = mul_a * mul_b;

   assign acc_sum   = acc + {{(ACC_W-2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};
   assign acc_shift = acc_sum >>> FRAC_BITS;

   assign j_nxt      = (j_cnt == LAST_J) ? '0 : j_cnt + J_W'(1);
   assign acc_reload = (j_cnt == LAST_J) ? '0 : bias_load(bias_r[j_nxt]);
   assign last_mac   = (state == BUSY) && (i_cnt == LAST_I) && (j_cnt == LAST_J);

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned (which would infer a latch).
   always_comb begin
      fin_word = acc_shift[WORD_SIZE-1:0];
      if (acc_shift > SAT_MAX) begin
         fin_word = {1'b0, {(WORD_SIZE-1){1'b1}}};
      end else if (acc_shift < SAT_MIN) begin
         fin_word = {1'b1, {(WORD_SIZE-1){1'b0}}};
      end
      if ((RELU != 0) && fin_word[WORD_SIZE-1]) begin
         fin_word = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------------

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples values from before the edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid_i)  state_nxt = BUSY;
         BUSY:    if (last_mac) state_nxt = DONE;
         DONE:    if (yumi_i)   state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_o = 1'b0;
      valid_o = 1'b0;
      case (state)
         IDLE:    ready_o = 1'b1;
         DONE:    valid_o = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Operand capture
   // ---------------------------------------------------------------------------

   // NOTE: the captured operands are not reset. They are always reloaded on
   // acceptance before they are read, so a reset would only add routing.
   always_ff @(posedge clk_i) begin
      if (state == IDLE && valid_i && !reset_i) begin
         data_r    <= data_i;
         weights_r <= weights_i;
         bias_r    <= bias_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Accumulator, counters and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc    <= '0;
         i_cnt  <= '0;
         j_cnt  <= '0;
         data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  acc   <= bias_load(bias_i[0]);
                  i_cnt <= '0;
                  j_cnt <= '0;
               end
            end
            BUSY: begin
               if (i_cnt == LAST_I) begin
                  // Neuron finished: publish it and preload the next bias.
                  data_o[j_cnt] <= fin_word;
                  i_cnt         <= '0;
                  j_cnt         <= j_nxt;
                  acc           <= acc_reload;
               end else begin
                  acc   <= acc_sum;
                  i_cnt <= i_cnt + I_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_fc_layer_seq
//   Directed bench for fc_layer_seq.
//
//   Two instances share one stimulus: one with RELU=0 and one with RELU=1.
//   A behavioural model tracks the handshake and computes each expected
//   result with plain integer arithmetic. A negedge compare process checks
//   both instances against the model every cycle. Literal expectations pin
//   the model itself.
// -----------------------------------------------------------------------------
module tb_fc_layer_seq;

   localparam int W = 16;
   localparam int N = 4;
   localparam int M = 3;
   localparam int F = 8;

   logic                       clk = 1'b0;
   logic                       reset_i;
   logic                       valid_i;
   logic                       yumi_i;
   logic [N-1:0][W-1:0]        data_i;
   logic [M-1:0][N-1:0][W-1:0] weights_i;
   logic [M-1:0][W-1:0]        bias_i;

   logic                       ready0, valid0, ready1, valid1;
   logic [M-1:0][W-1:0]        dout0, dout1;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   fc_layer_seq #(
      .WORD_SIZE(W), .INPUT_SIZE(N), .OUTPUT_SIZE(M), .FRAC_BITS(F), .RELU(0)
   ) dut0 (
      .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready0),
      .data_i(data_i), .weights_i(weights_i), .bias_i(bias_i),
      .valid_o(valid0), .yumi_i(yumi_i), .data_o(dout0)
   );

   fc_layer_seq #(
      .WORD_SIZE(W), .INPUT_SIZE(N), .OUTPUT_SIZE(M), .FRAC_BITS(F), .RELU(1)
   ) dut1 (
      .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready1),
      .data_i(data_i), .weights_i(weights_i), .bias_i(bias_i),
      .valid_o(valid1), .yumi_i(yumi_i), .data_o(dout1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: exact integer sum, floor shift, saturate, ReLU.
   function automatic logic [M-1:0][W-1:0] model(input logic [N-1:0][W-1:0] d,
                                                 input logic [M-1:0][N-1:0][W-1:0] w,
                                                 input logic [M-1:0][W-1:0] b,
                                                 input bit relu);
      logic [M-1:0][W-1:0] r;
      longint acc;
      longint max_v;
      longint min_v;
      max_v = (longint'(1) << (W-1)) - 1;
      min_v = -(longint'(1) << (W-1));
      for (int j = 0; j < M; j++) begin
         acc = longint'($signed(b[j])) * (longint'(1) << F);
         for (int i = 0; i < N; i++) begin
            acc += longint'($signed(w[j][i])) * longint'($signed(d[i]));
         end
         acc = acc >>> F;
         if (acc > max_v) acc = max_v;
         else if (acc < min_v) acc = min_v;
         if (relu && acc < 0) acc = 0;
         r[j] = acc[W-1:0];
      end
      return r;
   endfunction

   // Handshake model: idle -> (N*M cycles) -> result held until yumi.
   bit                  m_ready = 1'b1;
   bit                  m_valid = 1'b0;
   int                  m_left  = 0;
   logic [M-1:0][W-1:0] m_out0  = '0;
   logic [M-1:0][W-1:0] m_out1  = '0;
   logic [M-1:0][W-1:0] p0, p1;

   always @(posedge clk) begin
      if (reset_i) begin
         m_ready = 1'b1;
         m_valid = 1'b0;
         m_left  = 0;
         m_out0  = '0;
         m_out1  = '0;
      end else if (m_ready) begin
         if (valid_i) begin
            m_ready = 1'b0;
            m_left  = N*M;
            p0      = model(data_i, weights_i, bias_i, 1'b0);
            p1      = model(data_i, weights_i, bias_i, 1'b1);
         end
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_valid = 1'b1;
            m_out0  = p0;
            m_out1  = p1;
         end
      end else if (m_valid && yumi_i) begin
         m_valid = 1'b0;
         m_ready = 1'b1;
      end
   end

   // data_o is only defined outside the computation window.
   always @(negedge clk) begin
      if (chk_en) begin
         check("valid_o0", valid0, m_valid);
         check("ready_o0", ready0, m_ready);
         check("valid_o1", valid1, m_valid);
         check("ready_o1", ready1, m_ready);
         if (m_left == 0) begin
            check("data_o0", dout0, m_out0);
            check("data_o1", dout1, m_out1);
         end
      end
   end

   task automatic set_uniform(input logic [W-1:0] d, input logic [W-1:0] w, input logic [W-1:0] b);
      for (int i = 0; i < N; i++) data_i[i] = d;
      for (int j = 0; j < M; j++) begin
         bias_i[j] = b;
         for (int i = 0; i < N; i++) weights_i[j][i] = w;
      end
   endtask

   task automatic scramble();
      for (int i = 0; i < N; i++) data_i[i] = W'($urandom);
      for (int j = 0; j < M; j++) begin
         bias_i[j] = W'($urandom);
         for (int i = 0; i < N; i++) weights_i[j][i] = W'($urandom);
      end
   endtask

   // Entered at a negedge with the layer idle; returns at a negedge with
   // valid_o high (or after the cycle budget expires).
   task automatic run_vector(input bit mess_inputs);
      int lat;
      valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      if (mess_inputs) scramble();
      lat = 0;
      while (!valid0 && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("latency", lat, N*M);
   endtask

   task automatic consume();
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
      check("post_yumi_valid", valid0, 1'b0);
      check("post_yumi_ready", ready0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_i   = 1'b1;
      valid_i   = 1'b0;
      yumi_i    = 1'b0;
      data_i    = '0;
      weights_i = '0;
      bias_i    = '0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      check("reset_ready", ready0, 1'b1);
      check("reset_valid", valid0, 1'b0);
      check("reset_data",  dout0, '0);

      // Basic vector: 0.5 + 4 * 1.0 * 1.0 = 4.5 on every neuron.
      set_uniform(16'h0100, 16'h0100, 16'h0080);
      run_vector(1'b0);
      check("basic_data", dout0, 48'h0480_0480_0480);
      check("basic_ready_held", ready0, 1'b0);
      consume();

      // Saturation on both rails; ReLU clears the negative rail.
      @(negedge clk);
      set_uniform(16'h7F00, 16'h0000, 16'h0000);
      for (int i = 0; i < N; i++) begin
         weights_i[0][i] = 16'h7F00;
         weights_i[1][i] = 16'h8100;
      end
      run_vector(1'b0);
      check("sat_linear", dout0, 48'h0000_8000_7FFF);
      check("sat_relu",   dout1, 48'h0000_0000_7FFF);
      consume();

      // Floor rounding: 1 * -1 LSB product shifts to -1, not 0.
      set_uniform(16'h0000, 16'h0000, 16'h0000);
      data_i[0]       = 16'h0001;
      weights_i[0][0] = 16'hFFFF;
      run_vector(1'b0);
      check("floor_linear", dout0, 48'h0000_0000_FFFF);
      check("floor_relu",   dout1, 48'h0000_0000_0000);

      // Backpressure: result held, new vectors ignored while not consumed.
      for (int k = 0; k < 20; k++) begin
         valid_i = k[0];
         scramble();
         @(negedge clk);
         check("bp_ready", ready0, 1'b0);
         check("bp_valid", valid0, 1'b1);
         check("bp_data",  dout0, 48'h0000_0000_FFFF);
      end
      valid_i = 1'b0;
      consume();

      // Second vector after backpressure, with inputs changed after capture.
      set_uniform(16'h0100, 16'h0100, 16'h0080);
      run_vector(1'b1);
      check("hold_data", dout0, 48'h0480_0480_0480);
      consume();

      // Reset sampled on the fifth edge after acceptance.
      set_uniform(16'h0100, 16'h0100, 16'h0080);
      bias_i[2] = 16'h0180;
      valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      repeat (4) @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      check("rst_busy_valid", valid0, 1'b0);
      check("rst_busy_ready", ready0, 1'b1);
      check("rst_busy_data",  dout0, '0);

      // Reset and valid together: the vector must not be accepted.
      reset_i = 1'b1;
      valid_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      valid_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid_ready", ready0, 1'b1);

      // Recovery vector: neuron 2 has bias 1.5, so it ends at 5.5.
      run_vector(1'b0);
      check("recover_data", dout0, 48'h0580_0480_0480);
      consume();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
